// File: rtl/bcd_seg_scan.sv
// Multiplexed 4-digit BCD to 7-segment driver with a load-captured shadow
// register, per-digit prescaled scanning, leading-zero blanking and a non-BCD flag.
module bcd_seg_scan #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst_syn,
    input  logic [15:0] din,
    input  logic        load,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          err_q, err_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic [3:0] digit;
    logic [3:0] lead_zero;
    logic       non_bcd;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h40;
        endcase
    endfunction

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        err_d    = err_q;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        non_bcd = (din[3:0] > 4'd9) || (din[7:4] > 4'd9) ||
                  (din[11:8] > 4'd9) || (din[15:12] > 4'd9);
        if (load) begin
            shadow_d = din;
            err_d    = non_bcd;
        end

        // lead_zero[k]: digit k and every more-significant digit are zero; digit0 never blanks
        lead_zero[3] = (shadow_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (shadow_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (shadow_q[7:4] == 4'd0);
        lead_zero[0] = 1'b0;

        case (idx_q)
            2'd0:    digit = shadow_q[3:0];
            2'd1:    digit = shadow_q[7:4];
            2'd2:    digit = shadow_q[11:8];
            default: digit = shadow_q[15:12];
        endcase

        an_d  = 4'b0001 << idx_q;
        seg_d = seg_of(digit);
        if (BLANK_LZ && lead_zero[idx_q]) begin
            seg_d = 7'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_syn) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            shadow_q <= 16'h0000;
            err_q    <= 1'b0;
            an_q     <= 4'b0000;
            seg_q    <= 7'h00;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            err_q    <= err_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;
    assign err = err_q;
endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: clocks each digit stays enabled; legal range 1..65535.
REQ-002 SHALL have parameter BLANK_LZ, default 1: when 1, leading zeros are blanked.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_syn  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  16  four packed BCD digits: din[3:0]=digit0 (least significant) .. din[15:12]=digit3.
REQ-006 SHALL have port load  input  1  when high at a rising edge, din is captured into the shadow register.
REQ-007 SHALL have port seg  output  7  registered segment drive, active-high, seg[0]=a .. seg[6]=g.
REQ-008 SHALL have port an  output  4  registered one-hot digit enable, active-high, an[k] selects digit k.
REQ-009 SHALL have port err  output  1  registered flag: last captured value contained a non-BCD digit.

Function
REQ-010 SHALL hold a 16-bit shadow register; on load, shadow <= din; otherwise it holds.
REQ-011 SHALL keep a prescaler cnt counting 0..SCAN_DIV-1; at SCAN_DIV-1, cnt wraps to 0 and scan index idx advances (3 -> 0 wrap).
REQ-012 SHALL, with SCAN_DIV=1, advance idx every clock.
REQ-013 SHALL register an and seg every clock from the current idx and shadow: one-cycle latency from an idx or shadow change to the outputs.
REQ-014 SHALL set an to one-hot(idx) in every non-reset cycle; an is never all-zero outside reset.
REQ-015 SHALL encode digits as: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (hex).
REQ-016 SHALL encode any digit value 10..15 as 40 (dash, segment g only).
REQ-017 SHALL, when BLANK_LZ=1, drive seg=00 for digit k (k=1..3) when that digit and all more-significant digits equal 0; an still asserts.
REQ-018 SHALL never blank digit0.
REQ-019 SHALL treat a non-BCD digit as nonzero for blanking.
REQ-020 SHALL, when BLANK_LZ=0, never blank any digit.
REQ-021 SHALL, on load, set err <= 1 if any din nibble > 9, else 0; err holds between loads.
REQ-022 SHALL, when load coincides with an idx advance, drive the next cycle's outputs from the new idx and the old shadow, and the cycle after from the new shadow.
REQ-023 SHALL capture din on consecutive loads every cycle with no lost values; the last load wins.

Reset
REQ-024 SHALL, while rst_syn is high at a rising edge, set cnt=0, idx=0, shadow=0000, an=0000, seg=00, err=0.
REQ-025 SHALL give rst_syn priority over load in the same cycle; din is discarded.
REQ-026 SHALL, on rst_syn asserted mid-scan, abandon the current digit and restart at idx=0, cnt=0.
REQ-027 SHALL, in the first cycle after reset release, drive an=0001, seg=3F, with digits 1..3 blanked when BLANK_LZ=1.

Verification
REQ-028 SHALL cover reset: rst_syn high 2 cycles -> an=0000, seg=00, err=0; first cycle after release -> an=0001, seg=3F.
REQ-029 SHALL cover scanning: SCAN_DIV=4, load 1234 -> an 0001/0010/0100/1000, each held 4 cycles, with seg 66/4F/5B/06, repeating.
REQ-030 SHALL cover blanking: load 0050, BLANK_LZ=1 -> digit3, digit2 seg=00; digit1 seg=6D; digit0 seg=3F. With BLANK_LZ=0 -> digit3 and digit2 seg=3F.
REQ-031 SHALL cover the error flag: load 00A0 -> err=1, digit1 seg=40, digit2 and digit3 blanked; then load 0001 -> err=0, digit0 seg=06.
REQ-032 SHALL cover reset mid-scan: rst_syn at idx=2, cnt=1 with 1234 loaded -> next cycle an=0000, shadow=0000; after release, an=0001, seg=3F, and the scan restarts from digit0.
REQ-033 SHALL cover load coinciding with wrap: SCAN_DIV=1, load 9999 on the cycle idx advances -> one cycle showing the old value, then 6F on each digit.
